// File: rtl/fetch_mem_responder.sv
// ---------------------------------------------------------------------------
// fetch_mem_responder
//
// Instruction-memory responder for the fetch interface. Accepts fetch
// requests, classifies each address (misaligned / device region / outside the
// store), reads the word from the store in the acceptance cycle and answers
// in request order once the entry's latency countdown reaches zero.
// A side port writes the store for program loading.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop every outstanding request
//   req_valid_i/ready_o    fetch request handshake, req_addr_i = byte address
//   ans_valid_o/ready_i    answer handshake
//   ans_addr_o             address of the answered request
//   ans_instr_o            instruction word (0 when an exception is raised)
//   ans_except_raised_o    answer carries an exception
//   ans_except_code_o      0 = misaligned, 1 = access fault
//   ld_we_i/addr_i/data_i  program-load write port (word index)
// ---------------------------------------------------------------------------
module fetch_mem_responder #(
  parameter int unsigned WORDS     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 4,
  parameter logic [63:0] MMAP_MASK = 64'hffff_ffff_e000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_addr_i,
  output logic                     ans_valid_o,
  input  logic                     ans_ready_i,
  output logic [63:0]              ans_addr_o,
  output logic [31:0]              ans_instr_o,
  output logic                     ans_except_raised_o,
  output logic [1:0]               ans_except_code_o,
  input  logic                     ld_we_i,
  input  logic [$clog2(WORDS)-1:0] ld_addr_i,
  input  logic [31:0]              ld_data_i
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT1       = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [1:0]       EXC_MISAL  = 2'd0;
  localparam logic [1:0]       EXC_ACCESS = 2'd1;

  // Instruction store (not reset)
  logic [31:0] r_mem [WORDS];

  // Outstanding-request queue
  logic [63:0]      r_addr  [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic             r_exc   [DEPTH];
  logic [1:0]       r_code  [DEPTH];
  logic [CNT_W-1:0] r_cnt   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_ans_valid;
  logic [62:0]      w_word_sub;
  logic             w_out_of_range;
  logic             w_exc;
  logic [1:0]       w_code;
  logic [31:0]      w_instr;

  // Word index relative to the base. Misaligned addresses are rejected before
  // the range check, so the low two bits never take part in the subtraction;
  // bit 62 is the borrow, i.e. the address lies below BASE_ADDR.
  assign w_word_sub     = {1'b0, req_addr_i[63:2]} - {1'b0, BASE_ADDR[63:2]};
  assign w_out_of_range = w_word_sub[62] | (|w_word_sub[61:IDX_W]);

  assign req_ready_o = (r_count != FULL_CNT);
  assign w_ans_valid = r_vld[r_rd_ptr] & (r_cnt[r_rd_ptr] == CNT_ZERO);
  assign w_push      = req_valid_i & req_ready_o & ~flush_i;
  assign w_pop       = w_ans_valid & ans_ready_i & ~flush_i;

  // Answer outputs come straight from the head entry; they stay stable under
  // backpressure because the head is only modified on pop.
  assign ans_valid_o         = w_ans_valid;
  assign ans_addr_o          = r_addr[r_rd_ptr];
  assign ans_instr_o         = r_instr[r_rd_ptr];
  assign ans_except_raised_o = r_exc[r_rd_ptr];
  assign ans_except_code_o   = r_code[r_rd_ptr];

  // Classify the request address and pick the word to enqueue
  always_comb begin
    w_exc   = 1'b0;
    w_code  = EXC_MISAL;
    w_instr = 32'd0;
    if (req_addr_i[1:0] != 2'b00) begin
      w_exc  = 1'b1;
      w_code = EXC_MISAL;
    end else if ((req_addr_i & MMAP_MASK) != 64'd0) begin
      w_exc  = 1'b1;
      w_code = EXC_ACCESS;
    end else if (w_out_of_range) begin
      w_exc  = 1'b1;
      w_code = EXC_ACCESS;
    end else begin
      // Combinational read sees the pre-edge contents, so a same-cycle
      // load write to this word is not visible to this fetch.
      w_instr = r_mem[w_word_sub[IDX_W-1:0]];
    end
  end

  // Program-load write port
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      r_mem[ld_addr_i] <= ld_data_i;
    end
  end

  // Queue pointers, occupancy, per-entry countdown and entry payload
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W + 1){1'b0}};
      r_vld    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= 64'd0;
        r_instr[i] <= 32'd0;
        r_exc[i]   <= 1'b0;
        r_code[i]  <= 2'd0;
        r_cnt[i]   <= CNT_ZERO;
      end
    end else if (flush_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W + 1){1'b0}};
      r_vld    <= {DEPTH{1'b0}};
    end else begin
      // Countdown runs independently of answer backpressure
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_cnt[i] != CNT_ZERO)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_ONE;
      end
      // Push slot never equals the pop slot: push needs not-full, pop needs
      // non-empty, and the pointers only coincide at full or empty.
      if (w_push) begin
        r_vld[r_wr_ptr]   <= 1'b1;
        r_addr[r_wr_ptr]  <= req_addr_i;
        r_instr[r_wr_ptr] <= w_instr;
        r_exc[r_wr_ptr]   <= w_exc;
        r_code[r_wr_ptr]  <= w_code;
        r_cnt[r_wr_ptr]   <= CNT_INIT;
        r_wr_ptr          <= r_wr_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT1;
        2'b01:   r_count <= r_count - CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
module tb_fetch_mem_responder;

  localparam int          WORDS = 1024;
  localparam int          DEPTH = 4;
  localparam int          LAT0  = 1;
  localparam int          LAT1  = 3;
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h2000;
  localparam logic [63:0] MASK  = 64'hffff_ffff_e000_0000;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        req_valid = 1'b0;
  logic        ans_ready = 1'b0;
  logic        ld_we     = 1'b0;
  logic [63:0] req_addr  = 64'd0;
  logic [9:0]  ld_addr   = 10'd0;
  logic [31:0] ld_data   = 32'd0;

  logic [1:0]  rdy;
  logic [1:0]  avld;
  logic [1:0]  aexc;
  logic [63:0] aaddr  [2];
  logic [31:0] ainstr [2];
  logic [1:0]  acode  [2];

  always #5 clk = ~clk;

  fetch_mem_responder #(.WORDS(WORDS), .BASE_ADDR(BASE0), .LATENCY(LAT0), .DEPTH(DEPTH), .MMAP_MASK(MASK)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_addr_i(req_addr), .ans_valid_o(avld[0]), .ans_ready_i(ans_ready), .ans_addr_o(aaddr[0]),
    .ans_instr_o(ainstr[0]), .ans_except_raised_o(aexc[0]), .ans_except_code_o(acode[0]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  fetch_mem_responder #(.WORDS(WORDS), .BASE_ADDR(BASE1), .LATENCY(LAT1), .DEPTH(DEPTH), .MMAP_MASK(MASK)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_addr_i(req_addr), .ans_valid_o(avld[1]), .ans_ready_i(ans_ready), .ans_addr_o(aaddr[1]),
    .ans_instr_o(ainstr[1]), .ans_except_raised_o(aexc[1]), .ans_except_code_o(acode[1]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  // Reference model: per-DUT queue of pending answers, each tagged with the
  // cycle number from which it may be presented.
  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        exc;
    logic [1:0]  code;
    int          rdy_cyc;
  } ent_t;

  ent_t        mq [2][$];
  logic [31:0] mem_m [WORDS];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [63:0] addr;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] instr;
  } vec_t;

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [63:0] base_of(int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // {exc, code} from the address rules
  function automatic logic [2:0] classify(logic [63:0] a, logic [63:0] b);
    if (a % 4 != 0) return 3'b100;
    if ((a & MASK) != 64'd0) return 3'b101;
    if (a < b) return 3'b101;
    if ((a - b) / 4 >= WORDS) return 3'b101;
    return 3'b000;
  endfunction

  // Compare both DUTs against the model at the negedge, then advance the model
  // with the inputs seen at the posedge. Returns 1 ns after the posedge.
  task automatic tick();
    logic [1:0] ev;
    int         sz;
    ent_t       e;
    logic [2:0] c;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_req_ready", k), 64'(rdy[k]), 64'(mq[k].size() < DEPTH));
      ev[k] = (mq[k].size() > 0) && (cyc >= mq[k][0].rdy_cyc);
      chk($sformatf("d%0d_ans_valid", k), 64'(avld[k]), 64'(ev[k]));
      if (ev[k]) begin
        chk($sformatf("d%0d_ans_addr", k), aaddr[k], mq[k][0].addr);
        chk($sformatf("d%0d_ans_instr", k), 64'(ainstr[k]), 64'(mq[k][0].instr));
        chk($sformatf("d%0d_ans_exc", k), 64'(aexc[k]), 64'(mq[k][0].exc));
        chk($sformatf("d%0d_ans_code", k), 64'(acode[k]), 64'(mq[k][0].code));
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      sz = mq[k].size();
      if (!rst_n || flush) begin
        mq[k].delete();
      end else begin
        if (ev[k] && ans_ready) void'(mq[k].pop_front());
        if (req_valid && sz < DEPTH) begin
          c       = classify(req_addr, base_of(k));
          e.addr  = req_addr;
          e.exc   = c[2];
          e.code  = c[1:0];
          e.instr = 32'd0;
          if (!c[2]) e.instr = mem_m[int'((req_addr - base_of(k)) >> 2)];
          e.rdy_cyc = cyc + lat_of(k) - 1;
          mq[k].push_back(e);
        end
      end
    end
    if (ld_we) mem_m[ld_addr] = ld_data;
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    ans_ready = 1'b1;
    flush     = 1'b0;
    ld_we     = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic load(int idx, logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  vec_t        vecs [8];
  logic [63:0] held_addr;
  logic [31:0] held_instr;
  int          sel;

  initial begin
    vecs[0] = '{64'h180,                 1'b0, 2'd0, 32'h0000_0013};
    vecs[1] = '{64'h182,                 1'b1, 2'd0, 32'h0};
    vecs[2] = '{64'h2000_0000,           1'b1, 2'd1, 32'h0};
    vecs[3] = '{64'h1000,                1'b1, 2'd1, 32'h0};
    vecs[4] = '{64'hffc,                 1'b0, 2'd0, 32'hcafe_0001};
    vecs[5] = '{64'h1001,                1'b1, 2'd0, 32'h0};
    vecs[6] = '{64'h2000_0002,           1'b1, 2'd0, 32'h0};
    vecs[7] = '{64'h8000_0000_0000_0000, 1'b1, 2'd1, 32'h0};

    // Reset values
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_d%0d_ready", k), 64'(rdy[k]), 64'd1);
      chk($sformatf("rst_d%0d_valid", k), 64'(avld[k]), 64'd0);
      chk($sformatf("rst_d%0d_addr", k), aaddr[k], 64'd0);
      chk($sformatf("rst_d%0d_instr", k), 64'(ainstr[k]), 64'd0);
      chk($sformatf("rst_d%0d_exc", k), 64'(aexc[k]), 64'd0);
      chk($sformatf("rst_d%0d_code", k), 64'(acode[k]), 64'd0);
    end

    // Preload the whole store while in reset (store is not reset)
    for (int i = 0; i < WORDS; i++) load(i, $urandom);
    load(32'h60, 32'h0000_0013);
    load(32'h3ff, 32'hcafe_0001);
    rst_n = 1'b1;
    drain();

    // Table-driven single fetches, answered by the LATENCY=1 instance
    for (int v = 0; v < 8; v++) begin
      req_valid = 1'b1;
      req_addr  = vecs[v].addr;
      tick();
      req_valid = 1'b0;
      chk($sformatf("vec%0d_valid", v), 64'(avld[0]), 64'd1);
      chk($sformatf("vec%0d_addr", v), aaddr[0], vecs[v].addr);
      chk($sformatf("vec%0d_exc", v), 64'(aexc[0]), 64'(vecs[v].exc));
      chk($sformatf("vec%0d_code", v), 64'(acode[0]), 64'(vecs[v].code));
      chk($sformatf("vec%0d_instr", v), 64'(ainstr[0]), 64'(vecs[v].instr));
      tick();
    end
    drain();

    // Backpressure on the LATENCY=3 instance: fill, hold, release
    ans_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      req_valid = 1'b1;
      req_addr  = 64'h2000 + 64'(4 * j);
      tick();
    end
    req_valid = 1'b0;
    chk("bp_full_ready", 64'(rdy[1]), 64'd0);
    for (int j = 0; j < 3; j++) tick();
    chk("bp_head_valid", 64'(avld[1]), 64'd1);
    held_addr  = aaddr[1];
    held_instr = ainstr[1];
    for (int j = 0; j < 3; j++) tick();
    chk("bp_hold_valid", 64'(avld[1]), 64'd1);
    chk("bp_hold_addr", aaddr[1], held_addr);
    chk("bp_hold_instr", 64'(ainstr[1]), 64'(held_instr));
    ans_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp_rel%0d_valid", j), 64'(avld[1]), 64'd1);
      chk($sformatf("bp_rel%0d_addr", j), aaddr[1], 64'h2000 + 64'(4 * j));
      chk($sformatf("bp_rel%0d_instr", j), 64'(ainstr[1]), 64'(mem_m[j]));
      tick();
    end
    chk("bp_empty_valid", 64'(avld[1]), 64'd0);
    drain();

    // Flush with three pending entries and a simultaneous request
    ans_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      req_valid = 1'b1;
      req_addr  = 64'h2010 + 64'(4 * j);
      tick();
    end
    flush    = 1'b1;
    req_addr = 64'h2100;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    ans_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("fl%0d_d%0d_ready", j, k), 64'(rdy[k]), 64'd1);
        chk($sformatf("fl%0d_d%0d_valid", j, k), 64'(avld[k]), 64'd0);
      end
      tick();
    end

    // Same-cycle load and fetch of the same word: old data, then new data
    ans_ready = 1'b1;
    ld_we     = 1'b1;
    ld_addr   = 10'h60;
    ld_data   = 32'hdead_beef;
    req_valid = 1'b1;
    req_addr  = 64'h180;
    tick();
    ld_we = 1'b0;
    chk("ldcol_old", 64'(ainstr[0]), 64'h0000_0013);
    tick();
    req_valid = 1'b0;
    chk("ldcol_new", 64'(ainstr[0]), 64'hdead_beef);
    drain();

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      sel       = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: req_addr = 64'($urandom_range(0, 4095)) << 2;
        4:          req_addr = 64'($urandom_range(0, 16383)) | 64'd1;
        5:          req_addr = 64'h2000_0000 | (64'($urandom_range(0, 1023)) << 2);
        6:          req_addr = {$urandom, $urandom} & ~64'd3;
        default: begin
          case ($urandom_range(0, 5))
            0:       req_addr = 64'hffc;
            1:       req_addr = 64'h1000;
            2:       req_addr = 64'h1ffc;
            3:       req_addr = 64'h2000;
            4:       req_addr = 64'h2ffc;
            default: req_addr = 64'h3000;
          endcase
        end
      endcase
      ans_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      ld_we     = ($urandom_range(0, 7) == 0);
      ld_addr   = 10'($urandom_range(0, WORDS - 1));
      ld_data   = $urandom;
      tick();
    end
    drain();

    // Asynchronous reset mid-stream with entries queued
    ans_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      req_valid = 1'b1;
      req_addr  = 64'h100 + 64'(4 * j);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("mid_pre_valid", 64'(avld[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    mq[0].delete();
    mq[1].delete();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_d%0d_ready", k), 64'(rdy[k]), 64'd1);
      chk($sformatf("arst_d%0d_valid", k), 64'(avld[k]), 64'd0);
      chk($sformatf("arst_d%0d_addr", k), aaddr[k], 64'd0);
      chk($sformatf("arst_d%0d_instr", k), 64'(ainstr[k]), 64'd0);
      chk($sformatf("arst_d%0d_exc", k), 64'(aexc[k]), 64'd0);
      chk($sformatf("arst_d%0d_code", k), 64'(acode[k]), 64'd0);
    end
    tick();
    tick();
    rst_n     = 1'b1;
    ans_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("post_rst%0d_valid", j), 64'(avld[0] | avld[1]), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_mem_responder.md
# fetch_mem_responder

Memory-side responder for the LEN5 fetch memory interface: accepts instruction fetch requests from the fetch unit and returns 32-bit instruction words in order after a fixed, parameterised latency. It provides a word-addressed instruction store, a side port for program loading, and instruction-fetch exceptions for misaligned, out-of-range and memory-mapped-region addresses. It is used as the instruction memory in core-level simulation and FPGA bring-up. It also covers the zero-wait-state corner that the fetch-unit spill-skip options must survive.

## Interface
Parameters:
- WORDS, 1024: instruction store size in 32-bit words (power of 2).
- BASE_ADDR, 64'h0: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to answer valid (>= 1).
- DEPTH, 4: maximum outstanding requests (power of 2, >= 2).
- MMAP_MASK, 64'hffffffffe0000000: any address with (addr & MMAP_MASK) != 0 is a device region, not instruction memory.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all outstanding requests (pipeline flush).
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  request can be accepted.
- req_addr_i  in  64  fetch byte address.
- ans_valid_o  out  1  answer valid.
- ans_ready_i  in  1  fetch unit accepts answer.
- ans_addr_o  out  64  address of the answered request.
- ans_instr_o  out  32  instruction word (0 on exception).
- ans_except_raised_o  out  1  answer carries an exception.
- ans_except_code_o  out  2  0 = instruction address misaligned, 1 = instruction access fault.
- ld_we_i  in  1  program-load write enable.
- ld_addr_i  in  $clog2(WORDS)  program-load word index.
- ld_data_i  in  32  program-load data.

## Operation
- The outstanding-request queue is a circular FIFO of DEPTH entries. Each entry holds: addr, instr, except_raised, except_code, cnt ($clog2(LATENCY+1) bits).
- Request fire = req_valid_i & req_ready_o & ~flush_i.
- req_ready_o = ~full. It does not depend on a same-cycle answer pop.
- On fire, enqueue an entry with cnt = LATENCY-1. instr is read from the store in the fire cycle.
- Exception check on enqueue, evaluated in this priority order:
  - req_addr_i[1:0] != 0: misaligned, code 0.
  - (req_addr_i & MMAP_MASK) != 0: access fault, code 1.
  - req_addr_i < BASE_ADDR or word index >= WORDS: access fault, code 1.
  - Otherwise: no exception.
- Word index = (req_addr_i - BASE_ADDR) >> 2.
- Every cycle, each valid entry with cnt != 0 decrements cnt, regardless of ans_ready_i.
- ans_valid_o = head entry valid and head cnt == 0. Answer outputs are driven directly from the head entry.
- Answer fire = ans_valid_o & ans_ready_i. On fire, the head is popped. Push and pop in the same cycle are both performed.
- Answers are returned strictly in request order.
- ld_we_i writes ld_data_i into the store at ld_addr_i on the clock edge.
- A same-cycle load write and fetch fire to the same word capture the OLD data.
- flush_i (synchronous) empties the queue: pointers and count go to 0. Any same-cycle request is discarded, and any same-cycle answer fire is ignored. The store contents are untouched.

## Timing
- Reset (rst_ni low, asynchronous): queue empty, req_ready_o = 1, ans_valid_o = 0, ans_addr_o = 0, ans_instr_o = 0, ans_except_raised_o = 0, ans_except_code_o = 0. Store contents are not reset.
- A request fired at edge t has ans_valid_o high from cycle t+LATENCY, provided all older entries have popped.
- With LATENCY = 1 and ans_ready_i held high, throughput is 1 answer per cycle with DEPTH >= 2.
- Full: req_ready_o = 0 in the cycle the count equals DEPTH. It rises in the cycle after the first pop.
- Empty: ans_valid_o = 0.
- Pointers wrap modulo DEPTH.
- Backpressure: while ans_ready_i = 0, ans_valid_o and all answer outputs hold stable.
- Reset asserted mid-operation discards all entries immediately.
- ans_valid_o never rises in the cycle after flush_i.

## Test plan
- Reset, load word 0x00000013 at index 0x60 (BASE_ADDR 0), fetch 0x180 with LATENCY=1 -> ans_valid_o in next cycle, ans_instr_o = 0x00000013, ans_addr_o = 0x180, no exception.
- Fetch 0x182 -> code 0. Fetch 0x20000000 -> code 1. Fetch 4*WORDS -> code 1. Each answer has ans_instr_o = 0.
- LATENCY=3, DEPTH=4, four back-to-back requests with ans_ready_i = 0 -> req_ready_o drops after the 4th. Answers stay held stable. Releasing ans_ready_i returns all four in order on consecutive cycles.
- flush_i asserted with 3 entries pending and a simultaneous request -> no answers appear, and req_ready_o = 1 next cycle.
- Same-cycle ld_we_i to index 0x60 (new value 0xdeadbeef) and fetch 0x180 -> answer returns the old value. An immediate second fetch returns 0xdeadbeef.
- Assert rst_ni low mid-stream with entries queued -> all outputs take reset values asynchronously, and no stale answer appears after release.
